mem_bus_arbiter: RTL and testbench

- Shares one single-port synchronous instruction/data SRAM between two requesters.
  - Instruction fetch: driven by the PC register's pc and ce.
  - Load/store: the MEM stage.
- Each access takes a configurable number of wait states.
- Generates per-requester stall requests so the pipeline controller can freeze stages until each access completes.
- Sits between the fetch/MEM stages and the memory macro.

---
 rtl/mem_bus_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port SRAM between instruction fetch and load/store, MEM first.
// Optional one-entry fetch buffer enabled by defining MEMBUS_INST_BUF_EN.
module mem_bus_arbiter #(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [3:0]        mem_sel_i,
   input  logic [31:0]       mem_wdata_i,
   input  logic              flush_i,
   output logic [31:0]       if_inst_o,
   output logic              if_done_o,
   output logic [31:0]       mem_rdata_o,
   output logic              mem_done_o,
   output logic              stallreq_if_o,
   output logic              stallreq_mem_o,
   output logic              ram_ce_o,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [3:0]        ram_sel_o,
   output logic [31:0]       ram_wdata_o,
   input  logic [31:0]       ram_rdata_i
);

   localparam logic [3:0] WaitCnt = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {StIdle, StIfBusy, StMemBusy} state_e;

   state_e            r_state, w_state_nxt;
   logic [3:0]        r_cnt, w_cnt_nxt;
   logic              r_ram_ce, w_ram_ce_nxt;
   logic              r_ram_we, w_ram_we_nxt;
   logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_nxt;
   logic [3:0]        r_ram_sel, w_ram_sel_nxt;
   logic [31:0]       r_ram_wdata, w_ram_wdata_nxt;
   logic              r_if_done, w_if_done_nxt;
   logic              r_mem_done, w_mem_done_nxt;
   logic [31:0]       r_if_inst, w_if_inst_nxt;
   logic [31:0]       r_mem_rdata, w_mem_rdata_nxt;
   logic              r_flush_tag, w_flush_tag_nxt;
   logic              w_if_elig, w_mem_elig;

`ifdef MEMBUS_INST_BUF_EN
   logic              r_buf_vld, w_buf_vld_nxt;
   logic [ADDR_W-1:0] r_buf_tag, w_buf_tag_nxt;
   logic [31:0]       r_buf_inst, w_buf_inst_nxt;
   logic              w_buf_hit;
`endif

   // A requester seeing its done pulse is not re-granted in that same cycle.
   assign w_if_elig  = if_req_i & ~r_if_done;
   assign w_mem_elig = mem_req_i & ~r_mem_done;

`ifdef MEMBUS_INST_BUF_EN
   assign w_buf_hit = w_if_elig & ~mem_req_i & ~flush_i & r_buf_vld & (if_addr_i == r_buf_tag);
`endif

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_ram_ce_nxt    = r_ram_ce;
      w_ram_we_nxt    = r_ram_we;
      w_ram_addr_nxt  = r_ram_addr;
      w_ram_sel_nxt   = r_ram_sel;
      w_ram_wdata_nxt = r_ram_wdata;
      w_if_done_nxt   = 1'b0;
      w_mem_done_nxt  = 1'b0;
      w_if_inst_nxt   = r_if_inst;
      w_mem_rdata_nxt = r_mem_rdata;
      w_flush_tag_nxt = r_flush_tag;
`ifdef MEMBUS_INST_BUF_EN
      w_buf_vld_nxt   = r_buf_vld;
      w_buf_tag_nxt   = r_buf_tag;
      w_buf_inst_nxt  = r_buf_inst;
`endif
      unique case (r_state)
         StIdle: begin
            w_flush_tag_nxt = 1'b0;
            if (w_mem_elig) begin
               w_state_nxt     = StMemBusy;
               w_cnt_nxt       = WaitCnt;
               w_ram_ce_nxt    = 1'b1;
               w_ram_we_nxt    = mem_we_i;
               w_ram_addr_nxt  = mem_addr_i;
               w_ram_sel_nxt   = mem_sel_i;
               w_ram_wdata_nxt = mem_wdata_i;
            end
`ifdef MEMBUS_INST_BUF_EN
            else if (w_buf_hit) begin
               w_if_done_nxt = 1'b1;
               w_if_inst_nxt = r_buf_inst;
            end
`endif
            else if (w_if_elig) begin
               w_state_nxt     = StIfBusy;
               w_cnt_nxt       = WaitCnt;
               w_ram_ce_nxt    = 1'b1;
               w_ram_we_nxt    = 1'b0;
               w_ram_addr_nxt  = if_addr_i;
               w_ram_sel_nxt   = 4'hF;
               w_ram_wdata_nxt = 32'h0;
               w_flush_tag_nxt = flush_i;
            end
         end
         StIfBusy: begin
            if (r_cnt != 4'd0) begin
               w_cnt_nxt       = r_cnt - 4'd1;
               w_flush_tag_nxt = r_flush_tag | flush_i;
            end else begin
               // A flush seen at any point of the access discards its result.
               if (!(r_flush_tag | flush_i)) begin
                  w_if_done_nxt = 1'b1;
                  w_if_inst_nxt = ram_rdata_i;
`ifdef MEMBUS_INST_BUF_EN
                  w_buf_vld_nxt  = 1'b1;
                  w_buf_tag_nxt  = r_ram_addr;
                  w_buf_inst_nxt = ram_rdata_i;
`endif
               end
               w_ram_ce_nxt    = 1'b0;
               w_ram_we_nxt    = 1'b0;
               w_flush_tag_nxt = 1'b0;
               w_state_nxt     = StIdle;
            end
         end
         StMemBusy: begin
            if (r_cnt != 4'd0) begin
               w_cnt_nxt = r_cnt - 4'd1;
            end else begin
               w_mem_done_nxt = 1'b1;
               if (!r_ram_we) begin
                  w_mem_rdata_nxt = ram_rdata_i;
               end
`ifdef MEMBUS_INST_BUF_EN
               if (r_ram_we && (r_ram_addr[ADDR_W-1:2] == r_buf_tag[ADDR_W-1:2])) begin
                  w_buf_vld_nxt = 1'b0;
               end
`endif
               w_ram_ce_nxt = 1'b0;
               w_ram_we_nxt = 1'b0;
               w_state_nxt  = StIdle;
            end
         end
         default: begin
            w_state_nxt  = StIdle;
            w_ram_ce_nxt = 1'b0;
            w_ram_we_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= StIdle;
         r_cnt       <= 4'd0;
         r_ram_ce    <= 1'b0;
         r_ram_we    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_sel   <= 4'h0;
         r_ram_wdata <= 32'h0;
         r_if_done   <= 1'b0;
         r_mem_done  <= 1'b0;
         r_if_inst   <= 32'h0;
         r_mem_rdata <= 32'h0;
         r_flush_tag <= 1'b0;
`ifdef MEMBUS_INST_BUF_EN
         r_buf_vld   <= 1'b0;
         r_buf_tag   <= '0;
         r_buf_inst  <= 32'h0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_ram_ce    <= w_ram_ce_nxt;
         r_ram_we    <= w_ram_we_nxt;
         r_ram_addr  <= w_ram_addr_nxt;
         r_ram_sel   <= w_ram_sel_nxt;
         r_ram_wdata <= w_ram_wdata_nxt;
         r_if_done   <= w_if_done_nxt;
         r_mem_done  <= w_mem_done_nxt;
         r_if_inst   <= w_if_inst_nxt;
         r_mem_rdata <= w_mem_rdata_nxt;
         r_flush_tag <= w_flush_tag_nxt;
`ifdef MEMBUS_INST_BUF_EN
         r_buf_vld   <= w_buf_vld_nxt;
         r_buf_tag   <= w_buf_tag_nxt;
         r_buf_inst  <= w_buf_inst_nxt;
`endif
      end
   end

   assign if_inst_o      = r_if_inst;
   assign if_done_o      = r_if_done;
   assign mem_rdata_o    = r_mem_rdata;
   assign mem_done_o     = r_mem_done;
   assign stallreq_if_o  = if_req_i & ~r_if_done;
   assign stallreq_mem_o = mem_req_i & ~r_mem_done;
   assign ram_ce_o       = r_ram_ce;
   assign ram_we_o       = r_ram_we;
   assign ram_addr_o     = r_ram_addr;
   assign ram_sel_o      = r_ram_sel;
   assign ram_wdata_o    = r_ram_wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter (WAIT_CYCLES=1): cycle table plus reset and fetch-buffer sequences.
// Fetch-buffer expectations follow MEMBUS_INST_BUF_EN.
module tb_mem_bus_arbiter;

   localparam logic [31:0] I0   = 32'h3C01_1234;
   localparam logic [31:0] I4   = 32'h8C22_0000;
   localparam logic [31:0] I40  = 32'h2402_0005;
   localparam logic [31:0] I8   = 32'h0000_0813;
   localparam logic [31:0] D100 = 32'hDEAD_BEEF;
   localparam logic [31:0] D104 = 32'h0BAD_F00D;

   logic        clk, rst;
   logic        if_req, mem_req, mem_we, flush;
   logic [31:0] if_addr, mem_addr, mem_wdata;
   logic [3:0]  mem_sel;
   logic [31:0] if_inst, mem_rdata, ram_addr, ram_wdata, ram_rdata;
   logic        if_done, mem_done, stall_if, stall_mem, ram_ce, ram_we;
   logic [3:0]  ram_sel;

   int n_tests = 0;
   int n_fail  = 0;

   mem_bus_arbiter #(.WAIT_CYCLES(1), .ADDR_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .if_req_i       (if_req),
      .if_addr_i      (if_addr),
      .mem_req_i      (mem_req),
      .mem_we_i       (mem_we),
      .mem_addr_i     (mem_addr),
      .mem_sel_i      (mem_sel),
      .mem_wdata_i    (mem_wdata),
      .flush_i        (flush),
      .if_inst_o      (if_inst),
      .if_done_o      (if_done),
      .mem_rdata_o    (mem_rdata),
      .mem_done_o     (mem_done),
      .stallreq_if_o  (stall_if),
      .stallreq_mem_o (stall_mem),
      .ram_ce_o       (ram_ce),
      .ram_we_o       (ram_we),
      .ram_addr_o     (ram_addr),
      .ram_sel_o      (ram_sel),
      .ram_wdata_o    (ram_wdata),
      .ram_rdata_i    (ram_rdata)
   );

   function automatic logic [31:0] ram_model(input logic [31:0] a);
      case (a)
         32'h000: ram_model = I0;
         32'h004: ram_model = I4;
         32'h008: ram_model = I8;
         32'h040: ram_model = I40;
         32'h080: ram_model = 32'h1111_1111;
         32'h100: ram_model = D100;
         32'h104: ram_model = D104;
         default: ram_model = 32'hA5A5_0000 ^ a;
      endcase
   endfunction

   assign ram_rdata = ram_model(ram_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ifr;
      logic [31:0] ifa;
      logic        mr, mw;
      logic [31:0] ma;
      logic [3:0]  ms;
      logic [31:0] md;
      logic        fl;
      logic        e_ifd, e_md, e_si, e_sm, e_ce, e_we;
      logic [31:0] e_inst, e_rd, e_addr;
      logic [3:0]  e_sel;
      logic [31:0] e_wd;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic ifr, input logic [31:0] ifa, input logic mr, input logic mw,
                      input logic [31:0] ma, input logic [3:0] ms, input logic [31:0] md,
                      input logic fl, input logic [5:0] e_flags, input logic [31:0] e_inst,
                      input logic [31:0] e_rd, input logic [31:0] e_addr,
                      input logic [3:0] e_sel, input logic [31:0] e_wd);
      vec_t v;
      v.ifr = ifr; v.ifa = ifa; v.mr = mr; v.mw = mw; v.ma = ma; v.ms = ms; v.md = md;
      v.fl = fl;
      {v.e_ifd, v.e_md, v.e_si, v.e_sm, v.e_ce, v.e_we} = e_flags;
      v.e_inst = e_inst; v.e_rd = e_rd; v.e_addr = e_addr; v.e_sel = e_sel; v.e_wd = e_wd;
      vecs.push_back(v);
   endtask

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_addr = 0;
      mem_sel = 0; mem_wdata = 0; flush = 0;
   endtask

   // Latency counted in cycles from the request cycle to the if_done cycle (99 = never).
   task automatic do_fetch(input logic [31:0] a, output int lat, output bit saw_ce);
      @(posedge clk); #1;
      if_req = 1; if_addr = a;
      lat = 99; saw_ce = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ram_ce) saw_ce = 1;
         if (if_done) begin
            lat = i;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      if_req = 0;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d);
      bit seen;
      @(posedge clk); #1;
      mem_req = 1; mem_we = 1; mem_addr = a; mem_sel = 4'hF; mem_wdata = d;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_done) begin
            seen = 1;
            break;
         end
         @(posedge clk); #1;
      end
      check("store_done_seen", 128'(seen), 128'(1));
      @(posedge clk); #1;
      mem_req = 0; mem_we = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat;
      bit  saw_ce;
      bit  saw_done;

      // Flags order: if_done, mem_done, stall_if, stall_mem, ram_ce, ram_we
      // fetch 0x0
      add(1, 0, 0, 0, 0, 0, 0, 0, 6'b001000, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0, 6'b001010, 0, 0, 0, 4'hF, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0, 6'b001010, 0, 0, 0, 4'hF, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 6'b100000, I0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, I0, 0, 0, 0, 0);
      // simultaneous IF 0x4 and MEM load 0x100
      add(1, 4, 1, 0, 32'h100, 4'hF, 0, 0, 6'b001100, I0, 0, 0, 0, 0);
      add(1, 4, 1, 0, 32'h100, 4'hF, 0, 0, 6'b001110, I0, 0, 32'h100, 4'hF, 0);
      add(1, 4, 1, 0, 32'h100, 4'hF, 0, 0, 6'b001110, I0, 0, 32'h100, 4'hF, 0);
      add(1, 4, 1, 0, 32'h100, 4'hF, 0, 0, 6'b011000, I0, D100, 0, 0, 0);
      add(1, 4, 0, 0, 0, 0, 0, 0, 6'b001010, I0, D100, 4, 4'hF, 0);
      add(1, 4, 0, 0, 0, 0, 0, 0, 6'b001010, I0, D100, 4, 4'hF, 0);
      add(1, 4, 0, 0, 0, 0, 0, 0, 6'b100000, I4, D100, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, I4, D100, 0, 0, 0);
      // store 0x200
      add(0, 0, 1, 1, 32'h200, 4'b0011, 32'hAABBCCDD, 0, 6'b000100, I4, D100, 0, 0, 0);
      add(0, 0, 1, 1, 32'h200, 4'b0011, 32'hAABBCCDD, 0, 6'b000111, I4, D100,
          32'h200, 4'b0011, 32'hAABBCCDD);
      add(0, 0, 1, 1, 32'h200, 4'b0011, 32'hAABBCCDD, 0, 6'b000111, I4, D100,
          32'h200, 4'b0011, 32'hAABBCCDD);
      add(0, 0, 1, 1, 32'h200, 4'b0011, 32'hAABBCCDD, 0, 6'b010000, I4, D100, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, I4, D100, 0, 0, 0);
      // flushed fetch 0x80, then fetch 0x40
      add(1, 32'h80, 0, 0, 0, 0, 0, 0, 6'b001000, I4, D100, 0, 0, 0);
      add(1, 32'h80, 0, 0, 0, 0, 0, 1, 6'b001010, I4, D100, 32'h80, 4'hF, 0);
      add(1, 32'h80, 0, 0, 0, 0, 0, 0, 6'b001010, I4, D100, 32'h80, 4'hF, 0);
      add(1, 32'h40, 0, 0, 0, 0, 0, 0, 6'b001000, I4, D100, 0, 0, 0);
      add(1, 32'h40, 0, 0, 0, 0, 0, 0, 6'b001010, I4, D100, 32'h40, 4'hF, 0);
      add(1, 32'h40, 0, 0, 0, 0, 0, 0, 6'b001010, I4, D100, 32'h40, 4'hF, 0);
      add(1, 32'h40, 0, 0, 0, 0, 0, 0, 6'b100000, I40, D100, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, I40, D100, 0, 0, 0);
      // load 0x104 with mem_req dropped mid-access
      add(0, 0, 1, 0, 32'h104, 4'hF, 0, 0, 6'b000100, I40, D100, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 6'b000010, I40, D100, 32'h104, 4'hF, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 6'b000010, I40, D100, 32'h104, 4'hF, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 6'b010000, I40, D104, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, I40, D104, 0, 0, 0);

      idle_inputs();
      rst = 1;
      #12;
      check("reset_state", {if_done, mem_done, stall_if, stall_mem, ram_ce, ram_we, ram_sel,
                            ram_addr, ram_wdata, if_inst, mem_rdata}, 128'(0));
      @(posedge clk); #1;
      rst = 0;

      foreach (vecs[i]) begin
         @(posedge clk); #1;
         if_req = vecs[i].ifr; if_addr = vecs[i].ifa; mem_req = vecs[i].mr;
         mem_we = vecs[i].mw; mem_addr = vecs[i].ma; mem_sel = vecs[i].ms;
         mem_wdata = vecs[i].md; flush = vecs[i].fl;
         @(negedge clk);
         check($sformatf("row%0d_ctl", i),
               {if_done, mem_done, stall_if, stall_mem, ram_ce, ram_we, if_inst, mem_rdata},
               {vecs[i].e_ifd, vecs[i].e_md, vecs[i].e_si, vecs[i].e_sm, vecs[i].e_ce,
                vecs[i].e_we, vecs[i].e_inst, vecs[i].e_rd});
         if (vecs[i].e_ce)
            check($sformatf("row%0d_bus", i), {ram_addr, ram_sel, ram_wdata},
                  {vecs[i].e_addr, vecs[i].e_sel, vecs[i].e_wd});
      end

      // Reset asserted while a load is on the bus
      @(posedge clk); #1;
      idle_inputs();
      mem_req = 1; mem_addr = 32'h100; mem_sel = 4'hF;
      @(posedge clk); #1;
      check("rst_busy_ce", 128'(ram_ce), 128'(1));
      #2 rst = 1;
      #1;
      check("rst_async", {ram_ce, ram_we, mem_done, if_done, ram_addr, mem_rdata, if_inst},
            128'(0));
      mem_req = 0;
      @(posedge clk); #1;
      rst = 0;
      saw_done = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         saw_done = saw_done | mem_done | if_done | ram_ce;
      end
      check("rst_no_done", 128'(saw_done), 128'(0));
      do_fetch(32'h0, lat, saw_ce);
      check("rst_refetch_lat", 128'(lat), 128'(3));
      check("rst_refetch_inst", 128'(if_inst), 128'(I0));

      // Repeated fetch of 0x8, then a store to 0x8 and another fetch
      do_fetch(32'h8, lat, saw_ce);
      check("fetch8_first_lat", 128'(lat), 128'(3));
      do_fetch(32'h8, lat, saw_ce);
`ifdef MEMBUS_INST_BUF_EN
      check("fetch8_second_lat", 128'(lat), 128'(1));
      check("fetch8_second_ce", 128'(saw_ce), 128'(0));
`else
      check("fetch8_second_lat", 128'(lat), 128'(3));
      check("fetch8_second_ce", 128'(saw_ce), 128'(1));
`endif
      check("fetch8_second_inst", 128'(if_inst), 128'(I8));
      do_store(32'h8, 32'h0000_0000);
      do_fetch(32'h8, lat, saw_ce);
      check("fetch8_after_store_lat", 128'(lat), 128'(3));
      check("fetch8_after_store_ce", 128'(saw_ce), 128'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
